// File: rtl/joypad_pkg.sv
// Shared definitions for the NES joypad poller.
//   joy_state_e : poller FSM states
//   BTN_*       : bit positions of each button in the parallel word
//   NUM_BITS    : serial bits shifted out per transaction
package joypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } joy_state_e;

  localparam int unsigned NUM_BITS  = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/joypad_sync.sv
// Two-flop synchroniser for the asynchronous pad data line.
//   clk_i : system clock
//   rst_i : synchronous active-high reset (flops load 1, the idle-high wire level)
//   d_i   : asynchronous input
//   q_o   : synchronised output, two cycles of latency
module joypad_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/joypad_poller.sv
// Autonomous NES controller poller. Every POLL_PERIOD cycles (when enabled and
// idle) it strobes the pad, clocks out 8 serial bits and publishes an
// active-high parallel button word.
//   clock      : system clock
//   reset      : synchronous active-high reset
//   enable     : permits new transactions (in-flight ones always complete)
//   joy_data   : pad serial data, asynchronous, active-low on the wire
//   joy_strobe : latch pulse to the pad (registered)
//   joy_clock  : shift clock to the pad (registered)
//   buttons    : [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right
//   valid      : one-cycle pulse in the cycle buttons is updated
// Build option: define JOYPAD_POLLER_DEBOUNCE_EN to only update buttons when two
// consecutive raw words agree.
module joypad_poller
  import joypad_pkg::*;
#(
  parameter int unsigned HALF_BIT    = 64,
  parameter int unsigned POLL_PERIOD = 350000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       joy_data,
  output logic       joy_strobe,
  output logic       joy_clock,
  output logic [7:0] buttons,
  output logic       valid
);

  localparam int unsigned PH_W  = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int unsigned CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_BITS);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BITS - 1);

  joy_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [PH_W-1:0]     ph_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [NUM_BITS-1:0] word_d;
  logic                strobe_q;
  logic                clk_q;
  logic [NUM_BITS-1:0] buttons_q;
  logic                valid_q;
  logic                tick;
  logic                data_sync;
  logic                data_bit;
  logic                load_en;

  joypad_sync u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (joy_data),
    .q_o   (data_sync)
  );

  // Wire is active-low; a pulled-up (unplugged) line reads as released.
  assign data_bit = ~data_sync;

  always_comb begin
    tick   = (cnt_q == CNT_LAST);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    // Raw word including the bit being sampled this cycle, so the final bit
    // can be published in the same edge that enters DONE.
    word_d = shift_q;
    word_d[idx_q] = data_bit;
  end

`ifdef JOYPAD_POLLER_DEBOUNCE_EN
  logic [NUM_BITS-1:0] prev_raw_q;
  assign load_en = (word_d == prev_raw_q);
`else
  assign load_en = 1'b1;
`endif

  // buttons/valid are registered on the edge entering DONE so that they are
  // visible exactly during the DONE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ph_q      <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      strobe_q  <= 1'b0;
      clk_q     <= 1'b0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
`ifdef JOYPAD_POLLER_DEBOUNCE_EN
      prev_raw_q <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick && enable) begin
            state_q  <= ST_STROBE;
            strobe_q <= 1'b1;
            ph_q     <= '0;
          end
        end
        ST_STROBE: begin
          if (ph_q == PH_LAST) begin
            state_q  <= ST_LOW;
            strobe_q <= 1'b0;
            ph_q     <= '0;
            idx_q    <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_LOW: begin
          if (ph_q == PH_LAST) begin
            shift_q <= word_d;
            ph_q    <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
              if (load_en) begin
                buttons_q <= word_d;
              end
`ifdef JOYPAD_POLLER_DEBOUNCE_EN
              prev_raw_q <= word_d;
`endif
            end else begin
              state_q <= ST_HIGH;
              clk_q   <= 1'b1;
            end
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (ph_q == PH_LAST) begin
            state_q <= ST_LOW;
            clk_q   <= 1'b0;
            ph_q    <= '0;
            idx_q   <= idx_q + 1'b1;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          strobe_q <= 1'b0;
          clk_q    <= 1'b0;
        end
      endcase
    end
  end

  assign joy_strobe = strobe_q;
  assign joy_clock  = clk_q;
  assign buttons    = buttons_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_joypad_poller.sv
module tb_joypad_poller;

  localparam int unsigned HB = 4;
  localparam int unsigned PP = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       joy_data;
  logic       joy_strobe;
  logic       joy_clock;
  logic [7:0] buttons;
  logic       valid;

  // Pad model: pad_wire[i] is the wire level presented for bit i (A first).
  logic [7:0] pad_wire = 8'hFF;
  logic [3:0] pad_idx  = 4'd0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int s_strobe_hi, s_first_strobe, s_clk_hi, s_clk_rise, s_valid, s_valid_cyc;
  logic [7:0] s_vbtn [4];
  logic prev_clk;

  joypad_poller #(
    .HALF_BIT    (HB),
    .POLL_PERIOD (PP)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .enable     (en),
    .joy_data   (joy_data),
    .joy_strobe (joy_strobe),
    .joy_clock  (joy_clock),
    .buttons    (buttons),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  always @(posedge joy_clock or posedge joy_strobe) begin
    if (joy_strobe) pad_idx <= 4'd0;
    else            pad_idx <= pad_idx + 4'd1;
  end

  assign joy_data = (pad_idx < 4'd8) ? pad_wire[pad_idx[2:0]] : 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    s_strobe_hi = 0; s_first_strobe = -1; s_clk_hi = 0; s_clk_rise = 0;
    s_valid = 0; s_valid_cyc = -1;
    for (int i = 0; i < 4; i++) s_vbtn[i] = 8'hxx;
  endtask

  // Advance n cycles, sampling mid-cycle on the falling edge.
  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      check("no_overlap", {31'd0, joy_strobe & joy_clock}, 32'd0);
      if (joy_strobe) begin
        s_strobe_hi++;
        if (s_first_strobe < 0) s_first_strobe = cyc;
      end
      if (joy_clock) s_clk_hi++;
      if (joy_clock && !prev_clk) s_clk_rise++;
      prev_clk = joy_clock;
      if (valid) begin
        if (s_valid < 4) s_vbtn[s_valid] = buttons;
        s_valid_cyc = cyc;
        s_valid++;
      end
    end
  endtask

  task automatic adv_to(input int target);
    adv(target - cyc);
  endtask

  initial begin
    // Reset and release; cyc 0 is the cycle after the last reset edge.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    prev_clk = joy_clock;
    check("rst_strobe",  {31'd0, joy_strobe}, 32'd0);
    check("rst_clock",   {31'd0, joy_clock},  32'd0);
    check("rst_buttons", {24'd0, buttons},    32'd0);
    check("rst_valid",   {31'd0, valid},      32'd0);

    // Idle pad: first transaction
    clear_stats();
    adv_to(99);
    check("pre_tick_strobe", s_strobe_hi, 0);
    clear_stats();
    adv_to(180);
    check("t1_first_strobe", s_first_strobe, 100);
    check("t1_strobe_len",   s_strobe_hi, HB);
    check("t1_clk_hi",       s_clk_hi, 7 * HB);
    check("t1_clk_pulses",   s_clk_rise, 7);
    check("t1_valid_cnt",    s_valid, 1);
    check("t1_valid_cyc",    s_valid_cyc, 164);
    check("t1_buttons",      {24'd0, s_vbtn[0]}, 32'h00);

    // Wire 0,1,1,0,1,1,1,0 (A first) -> A, Start, Right
    pad_wire = 8'h76;
    clear_stats();
    adv_to(380);
    check("t2_valid_cnt", s_valid, 2);
    check("t2_valid_cyc", s_valid_cyc, 364);
`ifdef JOYPAD_POLLER_DEBOUNCE_EN
    check("t2_buttons_a", {24'd0, s_vbtn[0]}, 32'h00);
`else
    check("t2_buttons_a", {24'd0, s_vbtn[0]}, 32'h89);
`endif
    check("t2_buttons_b", {24'd0, s_vbtn[1]}, 32'h89);

    // enable low across the tick at 399: nothing happens
    en = 1'b0;
    clear_stats();
    adv_to(480);
    check("dis_strobe", s_strobe_hi, 0);
    check("dis_valid",  s_valid, 0);
    en = 1'b1;
    clear_stats();
    adv_to(580);
    check("en_first_strobe", s_first_strobe, 500);
    check("en_valid_cnt",    s_valid, 1);
    check("en_valid_cyc",    s_valid_cyc, 564);
    check("en_buttons",      {24'd0, s_vbtn[0]}, 32'h89);
    check("en_buttons_hold", {24'd0, buttons}, 32'h89);

    // Reset in the HIGH phase of bit 3 (cycles 632..635)
    clear_stats();
    adv_to(633);
    check("mid_clock_high", {31'd0, joy_clock}, 32'd1);
    check("mid_clk_pulses", s_clk_rise, 4);
    rst = 1'b1;
    adv(1);
    check("abort_clock",   {31'd0, joy_clock},  32'd0);
    check("abort_strobe",  {31'd0, joy_strobe}, 32'd0);
    check("abort_buttons", {24'd0, buttons},    32'h00);
    check("abort_valid",   {31'd0, valid},      32'd0);
    adv(2);
    rst = 1'b0;
    cyc = 0;
    prev_clk = joy_clock;

    // Debounce sequence: raw 0x01 once, then 0x02 twice
    pad_wire = 8'hFE;
    clear_stats();
    adv_to(99);
    check("rel_no_strobe", s_strobe_hi, 0);
    adv_to(100);
    check("rel_strobe", {31'd0, joy_strobe}, 32'd1);
    adv_to(180);
    check("db1_valid_cnt", s_valid, 1);
    check("db1_valid_cyc", s_valid_cyc, 164);
`ifdef JOYPAD_POLLER_DEBOUNCE_EN
    check("db1_buttons", {24'd0, s_vbtn[0]}, 32'h00);
`else
    check("db1_buttons", {24'd0, s_vbtn[0]}, 32'h01);
`endif
    pad_wire = 8'hFD;
    clear_stats();
    adv_to(380);
    check("db23_valid_cnt", s_valid, 2);
`ifdef JOYPAD_POLLER_DEBOUNCE_EN
    check("db2_buttons", {24'd0, s_vbtn[0]}, 32'h00);
`else
    check("db2_buttons", {24'd0, s_vbtn[0]}, 32'h02);
`endif
    check("db3_buttons", {24'd0, s_vbtn[1]}, 32'h02);

    // Long run: per-cycle overlap checks inside adv
    clear_stats();
    adv(2000);
    check("long_valid_cnt", s_valid, 20);
    check("long_clk_pulses", s_clk_rise, 140);
    check("long_buttons", {24'd0, buttons}, 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joypad_poller.md
# joypad_poller

Autonomous NES controller poller sitting between the physical joypad pins and the NES core's controller input. It periodically strobes the pad, shifts out the 8 serial button bits, and presents a registered, active-high parallel button word. The core then consumes a stable word rather than driving the pad pins itself. The `joy_data` line is synchronised internally; `joy_strobe` and `joy_clock` are generated entirely on-chip.

## Interface
- `HALF_BIT`, default 64: clock cycles per strobe pulse and per `joy_clock` phase. Must be ≥ 3.
- `POLL_PERIOD`, default 350000: cycles between poll ticks. Must be ≥ 16·HALF_BIT + 2.
- `clock` input, 1 bit: system clock.
- `reset` input, 1 bit: reset is synchronous and active-high.
- `enable` input, 1 bit: permits new transactions. A transaction already in flight always completes.
- `joy_data` input, 1 bit: pad serial data, asynchronous, active-low on the wire.
- `joy_strobe` output, 1 bit: latch pulse to the pad.
- `joy_clock` output, 1 bit: shift clock to the pad.
- `buttons` output, 8 bits: active-high. [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- `valid` output, 1 bit: one-cycle pulse when a transaction completes.

## Operation
- `joy_data` passes through a 2-FF synchroniser. All sampling uses the synchronised value, inverted.
- Period counter:
  - Free-running over 0..POLL_PERIOD-1 and wraps.
  - A tick occurs when the count equals POLL_PERIOD-1.
  - A tick starts a transaction only when the FSM is in IDLE and `enable`=1. Otherwise the tick is dropped; ticks are never queued.
- FSM states: IDLE, STROBE, LOW, HIGH, DONE.
  - IDLE: strobe=0, clock=0. On an accepted tick, go to STROBE.
  - STROBE: strobe=1 for HALF_BIT cycles, then go to LOW with bit index 0.
  - LOW: clock=0 for HALF_BIT cycles.
    - In the last cycle, shift the sample into bit [index].
    - If index=7, go to DONE. Otherwise go to HIGH.
  - HIGH: clock=1 for HALF_BIT cycles, then increment index and go to LOW.
  - DONE: load the shift register into `buttons`, pulse `valid`, then go to IDLE.
- An unplugged pad leaves the wire pulled high, so it reads as `buttons`=8'h00. No error is flagged.
- `enable` dropping mid-transaction has no effect until the FSM returns to IDLE.

## Timing
- Reset values: joy_strobe=0, joy_clock=0, buttons=8'h00, valid=0, state IDLE, period counter 0, shift register 0, index 0.
- Reset asserted mid-transaction aborts it immediately. Both pad outputs return low in the cycle after reset is sampled, and `buttons` is cleared.
- First tick: POLL_PERIOD cycles after the first cycle with reset deasserted.
- Transaction length: STROBE starts the cycle after the tick.
  - Total: HALF_BIT strobe + 8·HALF_BIT low + 7·HALF_BIT high = 16·HALF_BIT cycles.
  - DONE is one further cycle; `buttons` updates and `valid` is high in that cycle.
- Input latency: a pad level change reaches the sample point 2 cycles later. HALF_BIT ≥ 3 guarantees it settles within the phase.
- Pad outputs are registered and glitch-free. `joy_strobe` and `joy_clock` are never high together.

## Configuration
- `JOYPAD_POLLER_DEBOUNCE_EN` defined:
  - Keep the previous raw word.
  - `buttons` loads only when the new raw word equals the previous raw word.
  - The raw word always updates.
  - `valid` still pulses every transaction.
  - Reset clears the previous raw word to 8'h00.
- `JOYPAD_POLLER_DEBOUNCE_EN` undefined: `buttons` loads on every DONE.

## Structure
- Package `joypad_pkg` holds:
  - The state enum type.
  - Button index constants BTN_A..BTN_RIGHT.
  - The bit count constant NUM_BITS=8.
- One sub-module, `joypad_sync`: the 2-FF synchroniser with reset value 1, which corresponds to the idle-high wire.

## Test plan
Use HALF_BIT=4 and POLL_PERIOD=100 throughout.
- Reset release, pad model idle:
  - Strobe rises at cycle 100 after release and stays high 4 cycles.
  - Exactly 7 clock pulses of 4 cycles each follow.
  - `valid` pulses once, at cycle 100+64, with `buttons`=8'h00.
- Pad model returning wire pattern 0,1,1,0,1,1,1,0 (A first) → `buttons`=8'h89 (A, Start, Right).
- `enable`=0 across a tick → no strobe and no `valid` for that period. `enable`=1 before the next tick → a transaction starts at that tick.
- Reset asserted during the HIGH phase of bit 3:
  - Next cycle: joy_clock=0 and buttons=8'h00.
  - The first new strobe appears 100 cycles after release.
- With `JOYPAD_POLLER_DEBOUNCE_EN` (debounce compiled in):
  - Pattern 8'h01 once, then 8'h02 twice → `buttons` stays 8'h00, then 8'h00, then 8'h02; `valid` pulses 3 times.
  - Without the macro, the same stimulus gives 8'h01, 8'h02, 8'h02.
- Over a long run, check on every cycle that strobe and clock are never high together.
